wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage directly downstream of the MEM stage.
- Registers the MEM-stage write-back triple (address, data, enable) in a MEM/WB pipeline register.
- Commits that triple into the architectural general-purpose register file.
- Serves the two combinational read ports used by ID, with same-cycle write-to-read bypass.
- Honours stall and flush from the pipeline control unit.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
REG_NUM, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall_mem  in  1  MEM stage stalled (ctrl unit)
stall_wb  in  1  WB stage stalled (ctrl unit)
flush  in  1  pipeline flush, kills the MEM/WB entry
mem_waddr  in  ADDR_W  destination register from MEM
mem_wdata  in  DATA_W  write data from MEM
mem_we  in  1  write enable from MEM
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data (combinational)
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data (combinational)
wb_waddr_o  out  ADDR_W  registered WB destination, for ID forwarding
wb_wdata_o  out  DATA_W  registered WB data
wb_we_o  out  1  registered WB enable

Behaviour:
MEM/WB register, rising edge, first matching rule wins:
1. rst = 1: wb_waddr_o = 0, wb_wdata_o = 0, wb_we_o = 0.
2. flush = 1: load bubble (all three zero).
3. stall_mem = 1 and stall_wb = 0: load bubble. The stalled MEM instruction must not commit twice.
4. stall_mem = 1 and stall_wb = 1: hold all three.
5. Otherwise: capture mem_waddr, mem_wdata, mem_we.
- stall_mem = 0 with stall_wb = 1 is illegal from ctrl. Treat it as hold (rule 4 behaviour) and flag it with a bench assertion.

Register file write, rising edge:
- rst = 1: clear all REG_NUM entries to 0. Reset wins over any write that cycle.
- Otherwise, if wb_we_o = 1, wb_waddr_o != 0 and stall_wb = 0: regs[wb_waddr_o] <= wb_wdata_o.
- Register 0 is never written and always reads 0.

Latency:
- MEM triple presented in cycle N is captured at edge N.
- It is visible on wb_*_o during cycle N+1 and written into regs at edge N+1.
- It is readable from regs from cycle N+2. During cycle N+1 it is returned via bypass.

Read ports (identical, combinational), priority order:
1. rst = 1: 0.
2. reN = 0: 0.
3. raddrN = 0: 0.
4. wb_we_o = 1, wb_waddr_o = raddrN, stall_wb = 0: bypass wb_wdata_o.
5. Otherwise: regs[raddrN].

Boundaries:
- Both ports may read the same address and both may bypass in the same cycle.
- Reset asserted mid-stall or mid-flush: reset wins and clears everything.
- A write to r0 with wb_we_o = 1 still appears on wb_*_o (forwarding logic masks it). The regfile discards it.
- No X on outputs after the first reset edge.

Decomposition:
- Shared defines header: RstEnable, WriteEnable/WriteDisable, ReadEnable/ReadDisable, ZeroWord, NOPRegAddr, RegBus/RegAddrBus widths, RegNum.
- One sub-module: regfile (storage, write port, two bypassing read ports).
- wb_stage holds the MEM/WB register and instantiates regfile.

Test Plan:
- Reset: hold rst for 2 cycles with mem_we = 1. Expect wb_*_o = 0, and rdata1/rdata2 = 0 for raddr 1..31 after rst drops.
- Write/readback: MEM drives r5 <= 0xDEADBEEF, we = 1, at cycle N. Expect wb_*_o = {5, 0xDEADBEEF, 1} in N+1. Expect raddr1 = 5, re1 = 1 to return 0xDEADBEEF in N+1 (bypass) and in N+2 (regs).
- r0: MEM writes r0 <= 0x12345678. Expect wb_we_o = 1 in N+1, but rdata1 for raddr1 = 0 to read 0 in N+1 and N+2.
- Stall bubble: stall_mem = 1, stall_wb = 0 with MEM r7 <= 0x1. Expect wb_we_o = 0 next cycle and r7 unchanged.
- Stall hold: stall_mem = stall_wb = 1 for 3 cycles after r9 <= 0xAA is captured. Expect wb_*_o held, no bypass, and r9 written only after the stall releases.
- Flush and read enables: flush = 1 with MEM r3 <= 0x55. Expect a bubble and r3 to remain its old value. With re2 = 0 and raddr2 = 3, expect rdata2 = 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared constants and widths for the write-back stage
// and its register file.
package wb_stage_pkg;

    localparam int RegBusW  = 32;
    localparam int RegAddrW = 5;
    localparam int RegNum   = 32;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    localparam logic [RegBusW-1:0]  ZeroWord   = '0;
    localparam logic [RegAddrW-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/wb_stage_regfile.sv
// Architectural GPR file: one write port fed by MEM/WB,
// two combinational read ports with same-cycle bypass.
module wb_stage_regfile
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = RegBusW,
    parameter int ADDR_W  = RegAddrW,
    parameter int REG_NUM = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam logic [DATA_W-1:0] Zero = DATA_W'(ZeroWord);
    localparam logic [ADDR_W-1:0] Nop  = ADDR_W'(NOPRegAddr);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic              wr_ok;

    assign wr_ok = (we == WriteEnable) && (waddr != Nop) && !stall;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= Zero;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // A commit landing this edge is visible to ID in the same cycle.
    always_comb begin
        rdata1 = Zero;
        if (rst == RstEnable) begin
            rdata1 = Zero;
        end else if (re1 == ReadDisable) begin
            rdata1 = Zero;
        end else if (raddr1 == Nop) begin
            rdata1 = Zero;
        end else if (wr_ok && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = Zero;
        if (rst == RstEnable) begin
            rdata2 = Zero;
        end else if (re2 == ReadDisable) begin
            rdata2 = Zero;
        end else if (raddr2 == Nop) begin
            rdata2 = Zero;
        end else if (wr_ok && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register plus the
// register file it commits into.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = RegBusW,
    parameter int ADDR_W  = RegAddrW,
    parameter int REG_NUM = RegNum
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_we,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              wb_we_o
);

    logic [ADDR_W-1:0] nxt_waddr;
    logic [DATA_W-1:0] nxt_wdata;
    logic              nxt_we;

    // A MEM-only stall inserts a bubble so the stalled
    // instruction commits once, when MEM finally releases it.
    // WB-only stall is not a legal ctrl output; it holds.
    always_comb begin
        nxt_waddr = wb_waddr_o;
        nxt_wdata = wb_wdata_o;
        nxt_we    = wb_we_o;
        if (flush) begin
            nxt_waddr = '0;
            nxt_wdata = '0;
            nxt_we    = WriteDisable;
        end else if (stall_wb) begin
            nxt_waddr = wb_waddr_o;
            nxt_wdata = wb_wdata_o;
            nxt_we    = wb_we_o;
        end else if (stall_mem) begin
            nxt_waddr = '0;
            nxt_wdata = '0;
            nxt_we    = WriteDisable;
        end else begin
            nxt_waddr = mem_waddr;
            nxt_wdata = mem_wdata;
            nxt_we    = mem_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
            wb_we_o    <= WriteDisable;
        end else begin
            wb_waddr_o <= nxt_waddr;
            wb_wdata_o <= nxt_wdata;
            wb_we_o    <= nxt_we;
        end
    end

    wb_stage_regfile #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall_wb),
        .we     (wb_we_o),
        .waddr  (wb_waddr_o),
        .wdata  (wb_wdata_o),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed steps then random traffic
// against an architectural model of the GPRs.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_we_o;

    always #5 clk = ~clk;

    wb_stage #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .REG_NUM (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_mem  (stall_mem),
        .stall_wb   (stall_wb),
        .flush      (flush),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wb_waddr_o (wb_waddr_o),
        .wb_wdata_o (wb_wdata_o),
        .wb_we_o    (wb_we_o)
    );

    int checks = 0;
    int passed = 0;

    // Model: architectural register values plus the one
    // instruction sitting in WB waiting to retire.
    logic [31:0] m_regs [32];
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_we;

    logic [31:0] old_val;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ID sees the value the register holds once WB's pending
    // instruction retires at this edge (if it is allowed to).
    function automatic logic [31:0] exp_rd(input logic re,
                                           input logic [4:0] a);
        logic retires;
        if (rst || !re || a == 5'd0) return 32'd0;
        retires = m_we && !stall_wb && m_wa != 5'd0;
        if (retires && m_wa == a) return m_wd;
        return m_regs[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_wa = 5'd0;
            m_wd = 32'd0;
            m_we = 1'b0;
        end else begin
            if (m_we && m_wa != 5'd0 && !stall_wb) m_regs[m_wa] = m_wd;
            if (flush || (stall_mem && !stall_wb)) begin
                m_wa = 5'd0;
                m_wd = 32'd0;
                m_we = 1'b0;
            end else if (!stall_wb) begin
                m_wa = mem_waddr;
                m_wd = mem_wdata;
                m_we = mem_we;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("wb_waddr", 32'(wb_waddr_o), 32'(m_wa));
        chk("wb_wdata", wb_wdata_o, m_wd);
        chk("wb_we", 32'(wb_we_o), 32'(m_we));
        chk("rdata1", rdata1, exp_rd(re1, raddr1));
        chk("rdata2", rdata2, exp_rd(re2, raddr2));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; stall_mem = 0; stall_wb = 0;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0;
    endtask

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            assert (!(stall_wb && !stall_mem))
            else $error("FAIL illegal_stall: stall_wb without stall_mem");
        end
    end

    initial begin
        rst = 1; flush = 0; stall_mem = 0; stall_wb = 0;
        mem_we = 1; mem_waddr = 5'd4; mem_wdata = 32'hCAFE0004;
        re1 = 1; raddr1 = 5'd4; re2 = 1; raddr2 = 5'd4;
        m_wa = 0; m_wd = 0; m_we = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // Reset held two cycles with MEM trying to write.
        @(posedge clk);
        #1;
        tick();
        idle();
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            #1;
            chk("rst_rd1", rdata1, 32'd0);
            chk("rst_rd2", rdata2, 32'd0);
            tick();
        end

        // Write r5, read via bypass then via storage.
        mem_we = 1; mem_waddr = 5'd5; mem_wdata = 32'hDEADBEEF;
        raddr1 = 5'd5;
        tick();
        mem_we = 0;
        #1;
        chk("wr_waddr", 32'(wb_waddr_o), 32'd5);
        chk("wr_wdata", wb_wdata_o, 32'hDEADBEEF);
        chk("wr_we", 32'(wb_we_o), 32'd1);
        chk("wr_bypass", rdata1, 32'hDEADBEEF);
        tick();
        chk("wr_regs", rdata1, 32'hDEADBEEF);

        // r0 write is forwarded on wb_* but never lands.
        mem_we = 1; mem_waddr = 5'd0; mem_wdata = 32'h12345678;
        raddr1 = 5'd0;
        tick();
        mem_we = 0;
        #1;
        chk("r0_we", 32'(wb_we_o), 32'd1);
        chk("r0_byp", rdata1, 32'd0);
        tick();
        chk("r0_regs", rdata1, 32'd0);

        // MEM-only stall: bubble, r7 untouched.
        old_val = m_regs[7];
        stall_mem = 1;
        mem_we = 1; mem_waddr = 5'd7; mem_wdata = 32'h1;
        raddr1 = 5'd7;
        tick();
        idle();
        #1;
        chk("bub_we", 32'(wb_we_o), 32'd0);
        chk("bub_r7a", rdata1, old_val);
        tick();
        chk("bub_r7b", rdata1, old_val);

        // Full stall after r9 captured: held, no bypass, late write.
        old_val = m_regs[9];
        mem_we = 1; mem_waddr = 5'd9; mem_wdata = 32'hAA;
        raddr1 = 5'd9;
        tick();
        mem_we = 0;
        stall_mem = 1; stall_wb = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_waddr", 32'(wb_waddr_o), 32'd9);
            chk("hold_wdata", wb_wdata_o, 32'hAA);
            chk("hold_we", 32'(wb_we_o), 32'd1);
            chk("hold_nobyp", rdata1, old_val);
            tick();
        end
        idle();
        #1;
        chk("rel_byp", rdata1, 32'hAA);
        tick();
        chk("rel_regs", rdata1, 32'hAA);

        // Flush kills a pending r3 write; re2=0 masks port 2.
        mem_we = 1; mem_waddr = 5'd3; mem_wdata = 32'h77;
        tick();
        mem_we = 0;
        tick();
        flush = 1;
        mem_we = 1; mem_waddr = 5'd3; mem_wdata = 32'h55;
        tick();
        idle();
        raddr1 = 5'd3; re2 = 0; raddr2 = 5'd3;
        #1;
        chk("fl_we", 32'(wb_we_o), 32'd0);
        chk("fl_r3", rdata1, 32'h77);
        chk("fl_re2", rdata2, 32'd0);
        tick();
        chk("fl_r3b", rdata1, 32'h77);
        re2 = 1;

        // Reset in the middle of a stall and flush.
        stall_mem = 1; stall_wb = 1; flush = 1; rst = 1;
        tick();
        idle();
        raddr1 = 5'd5; raddr2 = 5'd9;
        #1;
        chk("rs_we", 32'(wb_we_o), 32'd0);
        chk("rs_r5", rdata1, 32'd0);
        chk("rs_r9", rdata2, 32'd0);
        tick();

        // Random traffic on a small address window.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0: begin stall_mem = 1; stall_wb = 0; end
                1: begin stall_mem = 1; stall_wb = 1; end
                default: begin stall_mem = 0; stall_wb = 0; end
            endcase
            mem_we = 1'($urandom_range(0, 1));
            mem_waddr = 5'($urandom_range(0, 7));
            mem_wdata = $urandom;
            re1 = ($urandom_range(0, 7) != 0);
            re2 = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                 : 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
